// File: rtl/duck_round_ctl.sv
// duck_round_ctl: round/wave sequencer for Duck Hunt.
// Launches ducks one at a time, commands the duck motion controller
// (hide/fly/freeze/fall-or-escape), counts shots, hits, ducks and rounds,
// and decides pass or game over at the end of every round.
//
// Optional feature macro: DUCK_ROUND_DOG_PAUSE_EN
//   defined   -> dog pause (PAUSE state, dog_show=1) between ducks and after
//                a passed round
//   undefined -> no pause, dog_show tied 0
//
// Ports:
//   aclk        in   system clock
//   rst         in   synchronous active-high reset
//   tick        in   one-cycle frame strobe; timers count only on it
//   start       in   new-game pulse (IDLE / GAME_OVER only)
//   trigger     in   gun fired pulse
//   hit         in   collision flag, qualified by trigger
//   duck_y      in   current duck y from the motion controller
//   duck_launch out  one-cycle pulse: reload duck spawn position
//   duck_cmd    out  0 HIDE, 1 FLY, 2 SHOT, 3 FALL/ESCAPE
//   shots_left  out  remaining shots for the current duck
//   duck_idx    out  0-based index of the current duck
//   hit_mask    out  bit i set when duck i was hit this round
//   round       out  round number 1..99 (0 after reset)
//   score       out  saturating score
//   dog_show    out  dog sprite enable
//   game_over   out  high in GAME_OVER
module duck_round_ctl #(
    parameter int unsigned DUCKS_PER_ROUND = 10,
    parameter int unsigned SHOTS_PER_DUCK  = 3,
    parameter int unsigned FLY_TICKS       = 300,
    parameter int unsigned SHOT_TICKS      = 30,
    parameter int unsigned ESC_TICKS       = 60,
    parameter int unsigned PAUSE_TICKS     = 60,
    parameter int unsigned PASS_HITS       = 6,
    parameter int unsigned GROUND_Y        = 520
) (
    input  logic                       aclk,
    input  logic                       rst,
    input  logic                       tick,
    input  logic                       start,
    input  logic                       trigger,
    input  logic                       hit,
    input  logic [10:0]                duck_y,
    output logic                       duck_launch,
    output logic [1:0]                 duck_cmd,
    output logic [1:0]                 shots_left,
    output logic [3:0]                 duck_idx,
    output logic [DUCKS_PER_ROUND-1:0] hit_mask,
    output logic [6:0]                 round,
    output logic [15:0]                score,
    output logic                       dog_show,
    output logic                       game_over
);

    localparam int unsigned TW = 16;
    localparam int unsigned CW = 5;
    localparam int unsigned MW = DUCKS_PER_ROUND;

    localparam logic [TW-1:0] FLY_LOAD   = TW'(FLY_TICKS);
    localparam logic [TW-1:0] SHOT_LOAD  = TW'(SHOT_TICKS);
    localparam logic [TW-1:0] ESC_LOAD   = TW'(ESC_TICKS);
    localparam logic [TW-1:0] PAUSE_LOAD = TW'(PAUSE_TICKS);

    localparam logic [1:0] CMD_HIDE = 2'd0;
    localparam logic [1:0] CMD_FLY  = 2'd1;
    localparam logic [1:0] CMD_SHOT = 2'd2;
    localparam logic [1:0] CMD_FALL = 2'd3;

    typedef enum logic [3:0] {
        S_IDLE,
        S_LAUNCH,
        S_FLY,
        S_SHOT,
        S_FALL,
        S_ESCAPE,
        S_NEXT,
        S_PAUSE,
        S_ROUND_END,
        S_GAME_OVER
    } state_t;

    state_t          state_q, state_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [1:0]      shots_q, shots_d;
    logic [3:0]      idx_q, idx_d;
    logic [MW-1:0]   mask_q, mask_d;
    logic [6:0]      round_q, round_d;
    logic [15:0]     score_q, score_d;
    logic [1:0]      cmd_q, cmd_d;
    logic            launch_q, launch_d;
    logic            dog_q, dog_d;
    logic            go_q, go_d;

    logic [TW-1:0]   tmr_dec;
    logic            tmr_exp;
    logic            shot_fired;
    logic [16:0]     score_sum;
    logic [15:0]     score_sat;
    logic [CW-1:0]   hits;

    // State and counter registers
    always_ff @(posedge aclk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            timer_q  <= '0;
            shots_q  <= '0;
            idx_q    <= '0;
            mask_q   <= '0;
            round_q  <= '0;
            score_q  <= '0;
            cmd_q    <= CMD_HIDE;
            launch_q <= 1'b0;
            dog_q    <= 1'b0;
            go_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            shots_q  <= shots_d;
            idx_q    <= idx_d;
            mask_q   <= mask_d;
            round_q  <= round_d;
            score_q  <= score_d;
            cmd_q    <= cmd_d;
            launch_q <= launch_d;
            dog_q    <= dog_d;
            go_q     <= go_d;
        end
    end

    // Next-state, counter updates and next registered outputs
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        shots_d = shots_q;
        idx_d   = idx_q;
        mask_d  = mask_q;
        round_d = round_q;
        score_d = score_q;

        // Exit fires on the tick that takes the timer to 0
        tmr_dec = (tick && (timer_q != '0)) ? timer_q - TW'(1) : timer_q;
        tmr_exp = tick && (timer_q <= TW'(1));

        shot_fired = trigger && (shots_q != 2'd0);

        score_sum = {1'b0, score_q} + 17'd500;
        score_sat = score_sum[16] ? 16'hFFFF : score_sum[15:0];

        hits = '0;
        for (int i = 0; i < int'(MW); i++) begin
            hits = hits + CW'(mask_q[i]);
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    round_d = 7'd1;
                    score_d = '0;
                    state_d = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                shots_d = 2'(SHOTS_PER_DUCK);
                timer_d = FLY_LOAD;
                state_d = S_FLY;
            end
            S_FLY: begin
                timer_d = tmr_dec;
                if (shot_fired) begin
                    shots_d = shots_q - 2'd1;
                end
                // A valid hit wins over timeout and last-shot exhaustion
                if (shot_fired && hit) begin
                    for (int i = 0; i < int'(MW); i++) begin
                        if (idx_q == 4'(i)) begin
                            mask_d[i] = 1'b1;
                        end
                    end
                    score_d = score_sat;
                    timer_d = SHOT_LOAD;
                    state_d = S_SHOT;
                end else if ((shot_fired && (shots_q == 2'd1)) || tmr_exp) begin
                    timer_d = ESC_LOAD;
                    state_d = S_ESCAPE;
                end
            end
            S_SHOT: begin
                timer_d = tmr_dec;
                if (tmr_exp) begin
                    state_d = S_FALL;
                end
            end
            S_FALL: begin
                if (duck_y >= 11'(GROUND_Y)) begin
                    state_d = S_NEXT;
                end
            end
            S_ESCAPE: begin
                timer_d = tmr_dec;
                if (tmr_exp) begin
                    state_d = S_NEXT;
                end
            end
            S_NEXT: begin
                // Prime the pause timer; LAUNCH reloads it when no pause follows
                timer_d = PAUSE_LOAD;
                if (idx_q == 4'(DUCKS_PER_ROUND - 1)) begin
                    state_d = S_ROUND_END;
                end else begin
                    idx_d = idx_q + 4'd1;
`ifdef DUCK_ROUND_DOG_PAUSE_EN
                    state_d = S_PAUSE;
`else
                    state_d = S_LAUNCH;
`endif
                end
            end
`ifdef DUCK_ROUND_DOG_PAUSE_EN
            S_PAUSE: begin
                timer_d = tmr_dec;
                if (tmr_exp) begin
                    state_d = S_LAUNCH;
                end
            end
`endif
            S_ROUND_END: begin
                if (hits >= CW'(PASS_HITS)) begin
                    round_d = (round_q >= 7'd99) ? 7'd99 : round_q + 7'd1;
                    idx_d   = '0;
                    mask_d  = '0;
`ifdef DUCK_ROUND_DOG_PAUSE_EN
                    timer_d = PAUSE_LOAD;
                    state_d = S_PAUSE;
`else
                    state_d = S_LAUNCH;
`endif
                end else begin
                    state_d = S_GAME_OVER;
                end
            end
            S_GAME_OVER: begin
                if (start) begin
                    round_d = 7'd1;
                    score_d = '0;
                    idx_d   = '0;
                    mask_d  = '0;
                    state_d = S_LAUNCH;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Outputs follow the state being entered
        case (state_d)
            S_FLY:    cmd_d = CMD_FLY;
            S_SHOT:   cmd_d = CMD_SHOT;
            S_FALL,
            S_ESCAPE: cmd_d = CMD_FALL;
            default:  cmd_d = CMD_HIDE;
        endcase
        launch_d = (state_d == S_LAUNCH);
        go_d     = (state_d == S_GAME_OVER);
`ifdef DUCK_ROUND_DOG_PAUSE_EN
        dog_d    = (state_d == S_PAUSE);
`else
        dog_d    = 1'b0;
`endif
    end

    assign duck_launch = launch_q;
    assign duck_cmd    = cmd_q;
    assign shots_left  = shots_q;
    assign duck_idx    = idx_q;
    assign hit_mask    = mask_q;
    assign round       = round_q;
    assign score       = score_q;
    assign dog_show    = dog_q;
    assign game_over   = go_q;

endmodule
